// File: rtl/sseg_decoder_pkg.sv
// rtl/sseg_decoder_pkg.sv - segment pattern constants and digit/frame types for sseg_decoder
package sseg_decoder_pkg;

    // Common-anode patterns {g,f,e,d,c,b,a}, a lit segment is driven low
    localparam logic [6:0] SSEG_0     = 7'h40;
    localparam logic [6:0] SSEG_1     = 7'h79;
    localparam logic [6:0] SSEG_2     = 7'h24;
    localparam logic [6:0] SSEG_3     = 7'h30;
    localparam logic [6:0] SSEG_4     = 7'h19;
    localparam logic [6:0] SSEG_5     = 7'h12;
    localparam logic [6:0] SSEG_6     = 7'h02;
    localparam logic [6:0] SSEG_7     = 7'h78;
    localparam logic [6:0] SSEG_8     = 7'h00;
    localparam logic [6:0] SSEG_9     = 7'h10;
    localparam logic [6:0] SSEG_A     = 7'h08;
    localparam logic [6:0] SSEG_B     = 7'h03;
    localparam logic [6:0] SSEG_C     = 7'h46;
    localparam logic [6:0] SSEG_D     = 7'h21;
    localparam logic [6:0] SSEG_E     = 7'h06;
    localparam logic [6:0] SSEG_F     = 7'h0E;
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        digit_t d3;
        digit_t d2;
        digit_t d1;
        digit_t d0;
    } frame_t;

endpackage

// File: rtl/sseg_pattern_lut.sv
// rtl/sseg_pattern_lut.sv - combinational 7-segment pattern to hex nibble decoder
module sseg_pattern_lut
    import sseg_decoder_pkg::*;
(
    input  logic [6:0] ca_i,
    output logic       valid_o,
    output digit_t     nibble_o
);

    always_comb begin
        valid_o  = 1'b1;
        nibble_o = 4'h0;
        case (ca_i)
            SSEG_0:  nibble_o = 4'h0;
            SSEG_1:  nibble_o = 4'h1;
            SSEG_2:  nibble_o = 4'h2;
            SSEG_3:  nibble_o = 4'h3;
            SSEG_4:  nibble_o = 4'h4;
            SSEG_5:  nibble_o = 4'h5;
            SSEG_6:  nibble_o = 4'h6;
            SSEG_7:  nibble_o = 4'h7;
            SSEG_8:  nibble_o = 4'h8;
            SSEG_9:  nibble_o = 4'h9;
            SSEG_A:  nibble_o = 4'hA;
            SSEG_B:  nibble_o = 4'hB;
            SSEG_C:  nibble_o = 4'hC;
            SSEG_D:  nibble_o = 4'hD;
            SSEG_E:  nibble_o = 4'hE;
            SSEG_F:  nibble_o = 4'hF;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - 7-segment scan bus read-back monitor; SSEG_DECODER_SYNC_EN adds a 2-flop input synchronizer
module sseg_decoder
    import sseg_decoder_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  sseg_ca,
    input  logic [3:0]  sseg_an,
    output digit_t      digit0,
    output digit_t      digit1,
    output digit_t      digit2,
    output digit_t      digit3,
    output logic        frame_valid,
    output logic [15:0] frame_value,
    output logic        frame_err,
    output logic        seg_err,
    output logic        an_err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(SETTLE_CYCLES - 1);

    logic [10:0]         samp_d;
    logic [10:0]         s_q, s_prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0][3:0]     dig_q, dig_d;
    logic [3:0]          seen_q, seen_d;
    logic                err_acc_q, err_acc_d;
    frame_t              frame_value_q, frame_value_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                seg_err_q, seg_err_d;
    logic                an_err_q, an_err_d;

`ifdef SSEG_DECODER_SYNC_EN
    logic [10:0] sync1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= {sseg_an, sseg_ca};
        end
    end

    assign samp_d = sync1_q;
`else
    assign samp_d = {sseg_an, sseg_ca};
`endif

    logic       capture;
    logic [3:0] an;
    logic       pat_valid;
    digit_t     pat_nibble;
    logic       blank, multi;
    logic [1:0] idx;
    logic [3:0] seen_new;

    assign an = s_q[10:7];

    sseg_pattern_lut u_lut (
        .ca_i     (s_q[6:0]),
        .valid_o  (pat_valid),
        .nibble_o (pat_nibble)
    );

    // Fires on the cycle cnt is about to saturate, so a held input captures once
    assign capture = (s_q == s_prev_q) && (cnt_q == CNT_CAP);

    always_comb begin
        cnt_d = cnt_q;
        if (s_q != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        blank = 1'b0;
        multi = 1'b0;
        idx   = 2'd0;
        case (an)
            4'b1110: idx   = 2'd0;
            4'b1101: idx   = 2'd1;
            4'b1011: idx   = 2'd2;
            4'b0111: idx   = 2'd3;
            4'b1111: blank = 1'b1;
            default: multi = 1'b1;
        endcase
    end

    assign seen_new = seen_q | (4'b0001 << idx);

    always_comb begin
        dig_d         = dig_q;
        seen_d        = seen_q;
        err_acc_d     = err_acc_q;
        frame_value_d = frame_value_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
        seg_err_d     = 1'b0;
        an_err_d      = 1'b0;
        if (capture && !blank) begin
            if (multi) begin
                an_err_d  = 1'b1;
                err_acc_d = 1'b1;
            end else if (!pat_valid) begin
                seg_err_d = 1'b1;
                err_acc_d = 1'b1;
            end else begin
                dig_d[idx] = pat_nibble;
                seen_d     = seen_new;
                if (seen_new == 4'hF) begin
                    frame_value_d = '{d3: dig_d[3], d2: dig_d[2], d1: dig_d[1], d0: dig_d[0]};
                    frame_err_d   = err_acc_q;
                    frame_valid_d = 1'b1;
                    seen_d        = 4'h0;
                    err_acc_d     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q           <= '0;
            s_prev_q      <= '0;
            cnt_q         <= '0;
            dig_q         <= '0;
            seen_q        <= '0;
            err_acc_q     <= 1'b0;
            frame_value_q <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            seg_err_q     <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            s_q           <= samp_d;
            s_prev_q      <= s_q;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            seen_q        <= seen_d;
            err_acc_q     <= err_acc_d;
            frame_value_q <= frame_value_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            seg_err_q     <= seg_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign digit0      = dig_q[0];
    assign digit1      = dig_q[1];
    assign digit2      = dig_q[2];
    assign digit3      = dig_q[3];
    assign frame_value = frame_value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign seg_err     = seg_err_q;
    assign an_err      = an_err_q;

endmodule

// File: tb/tb_sseg_decoder.sv
// tb/tb_sseg_decoder.sv - scoreboard bench for sseg_decoder with a step-level reference model
module tb_sseg_decoder;

    localparam int SETTLE = 4;
`ifdef SSEG_DECODER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int K_SEG = 0, K_AN = 1, K_FRAME = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  sseg_ca = 7'h7F;
    logic [3:0]  sseg_an = 4'hF;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic        frame_valid, frame_err, seg_err, an_err;
    logic [15:0] frame_value;

    sseg_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sseg_ca     (sseg_ca),
        .sseg_an     (sseg_an),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .frame_value (frame_value),
        .frame_err   (frame_err),
        .seg_err     (seg_err),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] val;
        logic        err;
    } ev_t;

    ev_t         expq[$];
    int          total = 0;
    int          bad = 0;
    logic [6:0]  pat [16];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_seen;
    logic        m_acc;
    logic [10:0] prev_in;
    bit          stop_mon = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int decode(input logic [6:0] c);
        for (int i = 0; i < 16; i++) if (pat[i] == c) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_seen = 4'h0;
        m_acc  = 1'b0;
    endtask

    // A step of n samples captures once when it lasts at least SETTLE+1 samples
    task automatic model_step(input logic [3:0] a, input logic [6:0] c, input int n);
        int   lows;
        int   pos;
        int   v;
        ev_t  e;
        if (n < SETTLE + 1 || a == 4'hF) return;
        lows = 0;
        pos  = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; pos = i; end
        if (lows > 1) begin
            e = '{kind: K_AN, val: 16'h0, err: 1'b0};
            expq.push_back(e);
            m_acc = 1'b1;
            return;
        end
        v = decode(c);
        if (v < 0) begin
            e = '{kind: K_SEG, val: 16'h0, err: 1'b0};
            expq.push_back(e);
            m_acc = 1'b1;
            return;
        end
        m_dig[pos]  = 4'(v);
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hF) begin
            e = '{kind: K_FRAME, val: {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}, err: m_acc};
            expq.push_back(e);
            m_seen = 4'h0;
            m_acc  = 1'b0;
        end
    endtask

    // Previous step's capture lands LAT edges into this step; check digits there
    task automatic step(input logic [3:0] a, input logic [6:0] c, input int n);
        logic [3:0] snap [4];
        for (int i = 0; i < 4; i++) snap[i] = m_dig[i];
        sseg_an = a;
        sseg_ca = c;
        prev_in = {a, c};
        model_step(a, c, n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == LAT - 1) begin
                chk("digit0", 32'(digit0), 32'(snap[0]));
                chk("digit1", 32'(digit1), 32'(snap[1]));
                chk("digit2", 32'(digit2), 32'(snap[2]));
                chk("digit3", 32'(digit3), 32'(snap[3]));
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_digits"}, 32'({digit3, digit2, digit1, digit0}), 32'h0);
        chk({nm, "_frame_value"}, 32'(frame_value), 32'h0);
        chk({nm, "_pulses"}, 32'({frame_valid, frame_err, seg_err, an_err}), 32'h0);
    endtask

    task automatic do_reset();
        step(4'hF, 7'h7F, LAT + 2);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        model_clear();
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_all_zero("reset_held");
        #2 rst_n = 1'b1;
        prev_in = 11'h7FF;
    endtask

    initial begin : monitor
        ev_t e;
        int  obs;
        forever begin
            @(negedge clk);
            if (!stop_mon && (seg_err || an_err || frame_valid)) begin
                obs = frame_valid ? K_FRAME : (seg_err ? K_SEG : K_AN);
                chk("pulse_onehot", 32'(int'(seg_err) + int'(an_err) + int'(frame_valid)), 32'd1);
                if (expq.size() == 0) begin
                    chk("unexpected_pulse_kind", 32'(obs), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_kind", 32'(obs), 32'(e.kind));
                    if (e.kind == K_FRAME && obs == K_FRAME) begin
                        chk("frame_value", 32'(frame_value), 32'(e.val));
                        chk("frame_err", 32'(frame_err), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] a;
        logic [6:0] c;
        int         r;
        int         lows;
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_clear();
        prev_in = 11'h7FF;
        #13;
        check_all_zero("reset_start");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // clean scan
        step(4'b1110, 7'h40, 10);
        step(4'b1101, 7'h79, 10);
        step(4'b1011, 7'h24, 10);
        step(4'b0111, 7'h30, 10);
        // glitch shorter than the settle window
        step(4'b1110, 7'h12, 4);
        // unknown pattern, then finish the frame with an error flag
        step(4'b1101, 7'h7E, 10);
        step(4'b1110, 7'h19, 10);
        step(4'b1101, 7'h79, 10);
        step(4'b1011, 7'h24, 10);
        step(4'b0111, 7'h30, 10);
        // anode conflict, blanking, then partial frame discarded by reset
        step(4'b1100, 7'h40, 10);
        step(4'b1111, 7'h7F, 50);
        step(4'b1110, 7'h02, 10);
        step(4'b1101, 7'h78, 10);
        do_reset();
        step(4'b1110, 7'h00, 10);
        step(4'b1101, 7'h10, 10);
        step(4'b1011, 7'h08, 10);
        step(4'b0111, 7'h03, 10);
        // repeated position within a frame
        step(4'b1110, 7'h46, 10);
        step(4'b1110, 7'h21, 10);
        step(4'b1101, 7'h06, 10);
        step(4'b1011, 7'h0E, 10);
        step(4'b0111, 7'h40, 10);

        for (int k = 0; k < 300; k++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r <= 5) begin
                    a = ~(4'b0001 << $urandom_range(0, 3));
                end else if (r == 6) begin
                    a = 4'hF;
                end else begin
                    do begin
                        a = 4'($urandom);
                        lows = 0;
                        for (int i = 0; i < 4; i++) if (!a[i]) lows++;
                    end while (lows < 2);
                end
                if ($urandom_range(0, 4) != 0) c = pat[$urandom_range(0, 15)];
                else c = 7'($urandom);
            end while ({a, c} == prev_in || {a, c} == 11'h0);
            step(a, c, $urandom_range(2, 9));
            if (k == 150) do_reset();
        end

        step(4'hF, 7'h7F, LAT + SETTLE + 10);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        stop_mon = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
